simon_controller: RTL and testbench

Sequencer for the Simon game datapath. Grows a stored 2-bit colour sequence by one random entry per round and plays it back on the display outputs (`simon_turn`, `simon_num`, `simon_pressed`). It then checks the player's presses against the stored sequence and flags loss or win. It sits between the random source and player-input debouncer on one side and the colour display/tone logic on the other.

---
 rtl/simon_controller.sv | 157 +++++++++++++++
 tb/tb_simon_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/simon_controller.sv
// Simon game sequencer: grows a random 2-bit colour sequence one entry per round,
// plays it back on the display outputs, then checks the player's presses against it.
module simon_controller #(
   parameter  int MAX_LEN     = 16,
   parameter  int SHOW_CYCLES = 4,
   parameter  int GAP_CYCLES  = 2,
   localparam int LW          = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    rnd,
   input  logic [1:0]    player_num,
   input  logic          player_pressed,
   output logic          simon_turn,
   output logic [1:0]    simon_num,
   output logic          simon_pressed,
   output logic [LW-1:0] level,
   output logic          game_over,
   output logic          win
);

   localparam int AW   = $clog2(MAX_LEN);
   localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      IDLE, ADD, SHOW_ON, SHOW_OFF, PLAY, LOSE, WIN
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          simon_turn_q, simon_turn_d;
   logic [1:0]    simon_num_q, simon_num_d;
   logic          simon_pressed_q, simon_pressed_d;
   logic          game_over_q, game_over_d;
   logic          win_q, win_d;

   logic [1:0]    mem [MAX_LEN];
   logic          mem_we;
   logic [AW-1:0] rd_addr;
   logic [1:0]    show_num;
   logic          last_idx;

   assign last_idx = (idx_q == level_q - LW'(1));

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE, LOSE, WIN: begin
            if (start) begin
               level_d = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            mem_we  = 1'b1;
            level_d = level_q + LW'(1);
            idx_d   = '0;
            timer_d = '0;
            state_d = SHOW_ON;
         end
         SHOW_ON: begin
            if (timer_q == TW'(SHOW_CYCLES - 1)) begin
               timer_d = '0;
               state_d = SHOW_OFF;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         SHOW_OFF: begin
            if (timer_q == TW'(GAP_CYCLES - 1)) begin
               if (last_idx) begin
                  idx_d   = '0;
                  state_d = PLAY;
               end else begin
                  idx_d   = idx_q + LW'(1);
                  timer_d = '0;
                  state_d = SHOW_ON;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         PLAY: begin
            if (player_pressed) begin
               if (player_num != mem[idx_q[AW-1:0]])
                  state_d = LOSE;
               else if (last_idx)
                  state_d = (level_q == LW'(MAX_LEN)) ? WIN : ADD;
               else
                  idx_d = idx_q + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered off the next state, so the colour entry being written
   // this cycle in ADD is forwarded straight from rnd.
   always_comb begin
      rd_addr  = idx_d[AW-1:0];
      show_num = (mem_we && (level_q[AW-1:0] == rd_addr)) ? rnd : mem[rd_addr];
      simon_turn_d    = (state_d == ADD) || (state_d == SHOW_ON) || (state_d == SHOW_OFF);
      simon_pressed_d = (state_d == SHOW_ON);
      simon_num_d     = ((state_d == SHOW_ON) || (state_d == SHOW_OFF)) ? show_num : 2'd0;
      game_over_d     = (state_d == LOSE);
      win_d           = (state_d == WIN);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values computed by the combinational blocks above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         level_q         <= '0;
         idx_q           <= '0;
         timer_q         <= '0;
         simon_turn_q    <= 1'b0;
         simon_num_q     <= 2'd0;
         simon_pressed_q <= 1'b0;
         game_over_q     <= 1'b0;
         win_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         level_q         <= level_d;
         idx_q           <= idx_d;
         timer_q         <= timer_d;
         simon_turn_q    <= simon_turn_d;
         simon_num_q     <= simon_num_d;
         simon_pressed_q <= simon_pressed_d;
         game_over_q     <= game_over_d;
         win_q           <= win_d;
      end
   end

   // NOTE: the sequence memory has no reset; each entry is written in ADD before
   // playback can read it, so clearing it would only cost logic.
   always_ff @(posedge clk) begin
      if (mem_we && !rst)
         mem[level_q[AW-1:0]] <= rnd;
   end

   assign simon_turn    = simon_turn_q;
   assign simon_num     = simon_num_q;
   assign simon_pressed = simon_pressed_q;
   assign level         = level_q;
   assign game_over     = game_over_q;
   assign win           = win_q;

endmodule

// File: tb/tb_simon_controller.sv
// Directed bench for simon_controller: a vector table for reset and the first rounds,
// then hand-timed sequences for loss, win (MAX_LEN=2) and reset during playback.
module tb_simon_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic [1:0] rnd = 2'd0;
   logic [1:0] player_num = 2'd0;
   logic       player_pressed = 1'b0;

   logic       simon_turn, simon_pressed, game_over, win;
   logic [1:0] simon_num;
   logic [4:0] level;

   logic       turn2, pressed2, game_over2, win2;
   logic [1:0] num2;
   logic [1:0] level2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   simon_controller dut (
      .clk(clk), .rst(rst), .start(start), .rnd(rnd),
      .player_num(player_num), .player_pressed(player_pressed),
      .simon_turn(simon_turn), .simon_num(simon_num), .simon_pressed(simon_pressed),
      .level(level), .game_over(game_over), .win(win)
   );

   simon_controller #(.MAX_LEN(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .rnd(rnd),
      .player_num(player_num), .player_pressed(player_pressed),
      .simon_turn(turn2), .simon_num(num2), .simon_pressed(pressed2),
      .level(level2), .game_over(game_over2), .win(win2)
   );

   typedef struct {
      logic       rst;
      logic       start;
      logic       pp;
      logic [1:0] pn;
      logic [1:0] rnd;
      logic       e_turn;
      logic [1:0] e_num;
      logic       e_pr;
      logic [4:0] e_lvl;
      logic       e_go;
      logic       e_win;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      start          = 1'b0;
      start2         = 1'b0;
      player_pressed = 1'b0;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press(input logic [1:0] c);
      player_num     = c;
      player_pressed = 1'b1;
      step();
   endtask

   initial begin
      //            rst  st   pp   pn    rnd   turn num  pr   lvl  go   win
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 2'd2, 1'b1, 5'd1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 2'd2, 1'b1, 5'd1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 1'b1, 2'd2, 1'b1, 5'd1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 2'd2, 1'b1, 5'd1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 2'd2, 1'b0, 5'd1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 1'b1, 2'd2, 1'b0, 5'd1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 5'd1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 5'd1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 2'd0, 1'b0, 5'd1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b1, 5'd2, 1'b0, 1'b0};

      for (int v = 0; v < 15; v++) begin
         rst            = vecs[v].rst;
         start          = vecs[v].start;
         player_pressed = vecs[v].pp;
         player_num     = vecs[v].pn;
         rnd            = vecs[v].rnd;
         step();
         check($sformatf("v%0d turn", v), int'(simon_turn), int'(vecs[v].e_turn));
         check($sformatf("v%0d num", v), int'(simon_num), int'(vecs[v].e_num));
         check($sformatf("v%0d pressed", v), int'(simon_pressed), int'(vecs[v].e_pr));
         check($sformatf("v%0d level", v), int'(level), int'(vecs[v].e_lvl));
         check($sformatf("v%0d game_over", v), int'(game_over), int'(vecs[v].e_go));
         check($sformatf("v%0d win", v), int'(win), int'(vecs[v].e_win));
      end

      // Round 2 playback of {2,0}: second colour lit from cycle 17, PLAY at 23.
      step_n(6);
      check("r2 second on num", int'(simon_num), 0);
      check("r2 second on pressed", int'(simon_pressed), 1);
      step_n(4);
      check("r2 second off pressed", int'(simon_pressed), 0);
      check("r2 second off turn", int'(simon_turn), 1);
      step_n(2);
      check("r2 play turn", int'(simon_turn), 0);
      press(2'd2);
      check("r2 first ok", int'(game_over), 0);
      press(2'd3);
      check("loss game_over", int'(game_over), 1);
      check("loss level", int'(level), 2);

      // Win on the MAX_LEN=2 instance while the first stays in LOSE.
      rnd    = 2'd1;
      start2 = 1'b1;
      step();
      check("w add turn", int'(turn2), 1);
      step_n(7);
      check("w r1 play turn", int'(turn2), 0);
      check("w r1 level", int'(level2), 1);
      press(2'd1);
      rnd = 2'd3;
      check("w r2 add turn", int'(turn2), 1);
      step_n(13);
      check("w r2 play turn", int'(turn2), 0);
      check("w r2 level", int'(level2), 2);
      press(2'd1);
      check("w not yet", int'(win2), 0);
      press(2'd3);
      check("w win", int'(win2), 1);
      check("w level", int'(level2), 2);
      check("w turn", int'(turn2), 0);
      press(2'd0);
      check("w held", int'(win2), 1);
      check("w level held", int'(level2), 2);
      check("lose held", int'(game_over), 1);
      check("lose level held", int'(level), 2);

      // Restart after loss, climb to round 3, then reset mid-SHOW_ON.
      rnd   = 2'd1;
      start = 1'b1;
      step();
      check("restart game_over", int'(game_over), 0);
      check("restart turn", int'(simon_turn), 1);
      step();
      check("restart level", int'(level), 1);
      check("restart num", int'(simon_num), 1);
      step_n(6);
      check("g r1 play", int'(simon_turn), 0);
      press(2'd1);
      rnd = 2'd2;
      step_n(13);
      check("g r2 play", int'(simon_turn), 0);
      press(2'd1);
      press(2'd2);
      check("g r3 add", int'(simon_turn), 1);
      rnd = 2'd3;
      step();
      check("g r3 level", int'(level), 3);
      check("g r3 lit", int'(simon_pressed), 1);
      rst = 1'b1;
      step();
      check("rst turn", int'(simon_turn), 0);
      check("rst pressed", int'(simon_pressed), 0);
      check("rst num", int'(simon_num), 0);
      check("rst level", int'(level), 0);
      rst = 1'b0;
      step();
      check("post rst idle", int'(simon_turn), 0);
      start = 1'b1;
      step();
      step();
      check("post rst level", int'(level), 1);
      check("post rst num", int'(simon_num), 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
